// File: rtl/acc_mem_pkg.sv
// ---------------------------------------------------------------------------
// acc_mem_pkg
// Shared definitions for the accumulator core's memory-side responder.
//   - Requester indices in arbitration ring order (write channel first, then
//     the fetch / operand-A / operand-B read channels).
//   - Read channel count and data word width.
//   - addr_bits(): number of word-address bits actually decoded for a given
//     array depth.
// ---------------------------------------------------------------------------
package acc_mem_pkg;

  // Ring order: W, R0 (fetch), R1 (opA), R2 (opB).
  localparam int REQ_W   = 0;
  localparam int REQ_R0  = 1;
  localparam int REQ_R1  = 2;
  localparam int REQ_R2  = 3;
  localparam int NUM_REQ = 4;

  // Number of independent read channels and the machine word width.
  localparam int NUM_RD = 3;
  localparam int WORD_W = 16;

  typedef logic [NUM_REQ-1:0] req_mask_t;
  typedef logic [1:0]         req_ptr_t;

  // Address bits needed to index a power-of-two array of 'depth' words.
  // A two-word array still needs one bit, so the result never drops below 1.
  function automatic int addr_bits(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/acc_mem_rr_arb.sv
// ---------------------------------------------------------------------------
// acc_mem_rr_arb
// Four-way round-robin arbiter, purely combinational. The caller owns the
// pointer register; this block only searches the ring and reports the result.
// Ports:
//   eligible  in   4  requesters allowed to win this cycle (ring order)
//   ptr       in   2  requester with highest priority this cycle
//   grant     out  4  one-hot grant, all zero when nothing is eligible
//   ptr_next  out  2  one past the granted requester; equals ptr when idle
//   any_grant out  1  a grant was issued this cycle
// ---------------------------------------------------------------------------
module acc_mem_rr_arb
  import acc_mem_pkg::*;
(
  input  req_mask_t eligible,
  input  req_ptr_t  ptr,
  output req_mask_t grant,
  output req_ptr_t  ptr_next,
  output logic      any_grant
);

  // Walk the ring starting at the pointer; the first eligible requester wins.
  // The 2-bit index wraps naturally, which is exactly the ring behaviour.
  always_comb begin
    req_ptr_t idx;
    grant     = '0;
    ptr_next  = ptr;
    any_grant = 1'b0;
    idx       = ptr;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = ptr + 2'(off);
      if (!any_grant && eligible[idx]) begin
        grant[idx] = 1'b1;
        ptr_next   = idx + 2'd1;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_mem_responder.sv
// ---------------------------------------------------------------------------
// acc_mem_responder
// Memory-side responder for the accumulator core. A DEPTH x 16 word array
// sits behind one access port shared by a write channel and three read
// channels (fetch, opA, opB). One requester is granted per cycle in
// round-robin order; reads return data a fixed READ_LAT cycles after grant.
//
// Parameters:
//   DEPTH     number of 16-bit words, power of two in 2..65536
//   READ_LAT  cycles from read grant to rsp_valid, 1 or 2
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   wr_valid   in   1   write request
//   wr_ready   out  1   write granted this cycle
//   wr_addr    in   16  write word address (upper bits ignored)
//   wr_data    in   16  write data
//   rd_valid   in   3   read requests: bit0 fetch, bit1 opA, bit2 opB
//   rd_ready   out  3   per-channel read grant this cycle
//   rd_addr    in   48  packed read addresses, channel i at [16i+15:16i]
//   rsp_valid  out  3   per-channel one-cycle response strobe
//   rsp_data   out  48  packed response data, held between strobes
//
// Optional build macro ACC_MEM_STATS_EN adds:
//   stat_grants     out 16  saturating count of grants
//   stat_conflicts  out 16  saturating count of cycles with 2+ valid requesters
// ---------------------------------------------------------------------------
module acc_mem_responder
  import acc_mem_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [WORD_W-1:0]        wr_addr,
  input  logic [WORD_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic [NUM_RD*WORD_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rsp_valid,
  output logic [NUM_RD*WORD_W-1:0] rsp_data
`ifdef ACC_MEM_STATS_EN
  ,
  output logic [15:0]              stat_grants,
  output logic [15:0]              stat_conflicts
`endif
);

  localparam int AW = addr_bits(DEPTH);

  // Reject illegal configurations at elaboration time.
  if ((DEPTH < 2) || (DEPTH > 65536) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("acc_mem_responder: DEPTH must be a power of two in 2..65536");
  end

  logic [WORD_W-1:0] mem [DEPTH];

  req_mask_t         eligible;
  req_mask_t         grant;
  req_ptr_t          ptr_q;
  req_ptr_t          ptr_next;
  logic              any_grant;

  logic              wr_grant;
  logic [NUM_RD-1:0] rd_grant;
  logic [NUM_RD-1:0] in_flight;

  logic [WORD_W-1:0] rd_sel_addr;
  logic [AW-1:0]     rd_index;
  logic [AW-1:0]     wr_index;
  logic [WORD_W-1:0] rd_word;

  logic [NUM_RD-1:0] rsp_valid_q;
  logic [WORD_W-1:0] rsp_data_q [NUM_RD];

  // Address bits above AW are ignored by design (addresses wrap modulo
  // DEPTH); fold the full buses here so they are visibly consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr, rd_addr};

  // A read channel with a request in flight sits out arbitration until its
  // response strobe. Eligibility is forced low during reset so no ready can
  // assert while rst_n is low, even if requesters already present valid.
  assign eligible = {rd_valid & ~in_flight, wr_valid} & {NUM_REQ{rst_n}};

  acc_mem_rr_arb u_arb (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .ptr_next  (ptr_next),
    .any_grant (any_grant)
  );

  assign wr_grant = grant[REQ_W];
  assign rd_grant = grant[REQ_R2:REQ_R0];
  assign wr_ready = wr_grant;
  assign rd_ready = rd_grant;

  // Only one grant per cycle, so a single mux selects the read address that
  // drives the array's one access port.
  always_comb begin
    rd_sel_addr = rd_addr[WORD_W-1:0];
    for (int c = 0; c < NUM_RD; c++) begin
      if (rd_grant[c]) begin
        rd_sel_addr = rd_addr[WORD_W*c +: WORD_W];
      end
    end
  end

  assign rd_index = rd_sel_addr[AW-1:0];
  assign wr_index = wr_addr[AW-1:0];
  assign rd_word  = mem[rd_index];

  // Array storage is deliberately not reset. Writes land on the grant edge,
  // so any read granted in a later cycle observes them.
  always_ff @(posedge clk) begin
    if (wr_grant) begin
      mem[wr_index] <= wr_data;
    end
  end

  // Grant pointer: moves one past the winner, holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= req_ptr_t'(REQ_W);
    end else if (any_grant) begin
      ptr_q <= ptr_next;
    end
  end

  // In-flight bits set on grant and clear on the cycle the response strobe
  // is driven, so a channel becomes eligible again right after its response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
    end else begin
      in_flight <= (in_flight & ~rsp_valid_q) | rd_grant;
    end
  end

  // Response pipeline. Each channel keeps its own data register so that
  // rsp_data holds the last delivered word while the strobe is low.
  if (READ_LAT == 1) begin : g_lat1
    // The array is sampled on the grant edge straight into the channel's
    // response register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rsp_valid_q <= '0;
        for (int c = 0; c < NUM_RD; c++) begin
          rsp_data_q[c] <= '0;
        end
      end else begin
        rsp_valid_q <= rd_grant;
        for (int c = 0; c < NUM_RD; c++) begin
          if (rd_grant[c]) begin
            rsp_data_q[c] <= rd_word;
          end
        end
      end
    end
  end else if (READ_LAT == 2) begin : g_lat2
    logic [NUM_RD-1:0] s1_valid;
    logic [WORD_W-1:0] s1_data;

    // Extra stage: the array word is captured on the grant edge into a
    // shared stage register, then steered to the owning channel one edge
    // later. Reset empties the stage so dropped reads never respond.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid    <= '0;
        s1_data     <= '0;
        rsp_valid_q <= '0;
        for (int c = 0; c < NUM_RD; c++) begin
          rsp_data_q[c] <= '0;
        end
      end else begin
        s1_valid    <= rd_grant;
        if (|rd_grant) begin
          s1_data <= rd_word;
        end
        rsp_valid_q <= s1_valid;
        for (int c = 0; c < NUM_RD; c++) begin
          if (s1_valid[c]) begin
            rsp_data_q[c] <= s1_data;
          end
        end
      end
    end
  end else begin : g_bad_lat
    $error("acc_mem_responder: READ_LAT must be 1 or 2");
  end

  assign rsp_valid = rsp_valid_q;

  always_comb begin
    rsp_data = '0;
    for (int c = 0; c < NUM_RD; c++) begin
      rsp_data[WORD_W*c +: WORD_W] = rsp_data_q[c];
    end
  end

`ifdef ACC_MEM_STATS_EN
  // Conflicts count raw valids, not eligibility: a cycle with two or more
  // requesters asking counts even if some of them are blocked in flight.
  logic conflict;
  assign conflict = ($countones({rd_valid, wr_valid}) >= 2);

  // Both counters saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants    <= '0;
      stat_conflicts <= '0;
    end else begin
      if (any_grant && (stat_grants != 16'hFFFF)) begin
        stat_grants <= stat_grants + 16'd1;
      end
      if (conflict && (stat_conflicts != 16'hFFFF)) begin
        stat_conflicts <= stat_conflicts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_acc_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_acc_mem_responder
// Drives one READ_LAT=1 and one READ_LAT=2 instance of acc_mem_responder
// from the same request stream. Each stimulus cycle carries hand-computed
// grant expectations per instance; granted reads push their expected
// response into a per-instance queue, and a negedge monitor pops and
// compares whenever an instance strobes rsp_valid.
// ---------------------------------------------------------------------------
module tb_acc_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_valid;
  logic [47:0] rd_addr;

  logic        wr_ready1, wr_ready2;
  logic [2:0]  rd_ready1, rd_ready2;
  logic [2:0]  rsp_valid1, rsp_valid2;
  logic [47:0] rsp_data1, rsp_data2;
`ifdef ACC_MEM_STATS_EN
  logic [15:0] stat_grants1, stat_conflicts1;
  logic [15:0] stat_grants2, stat_conflicts2;
`endif

  always #5 clk = ~clk;

  acc_mem_responder #(.DEPTH(256), .READ_LAT(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready1),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready1),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid1),
    .rsp_data  (rsp_data1)
`ifdef ACC_MEM_STATS_EN
    ,
    .stat_grants    (stat_grants1),
    .stat_conflicts (stat_conflicts1)
`endif
  );

  acc_mem_responder #(.DEPTH(256), .READ_LAT(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready2),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready2),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid2),
    .rsp_data  (rsp_data2)
`ifdef ACC_MEM_STATS_EN
    ,
    .stat_grants    (stat_grants2),
    .stat_conflicts (stat_conflicts2)
`endif
  );

  // Grant patterns as {rd_ready[2:0], wr_ready}.
  localparam logic [3:0] GN = 4'b0000;
  localparam logic [3:0] GW = 4'b0001;
  localparam logic [3:0] G0 = 4'b0010;
  localparam logic [3:0] G1 = 4'b0100;
  localparam logic [3:0] G2 = 4'b1000;

  typedef struct {
    int          cyc;
    int          ch;
    logic [15:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int cyc    = 0;
  int passed = 0;
  int total  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [47:0] got, input logic [47:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [47:0] ra1(input int ch, input logic [15:0] a);
    logic [47:0] r;
    r = '0;
    r[16*ch +: 16] = a;
    return r;
  endfunction

  // One bus cycle: drive requests just after the rising edge, sample the
  // combinational readies mid-cycle, compare with the expected grant for each
  // instance, and queue expected responses for the reads that should win.
  task automatic applyStimulus(input string name, input logic wv, input logic [15:0] wa,
                               input logic [15:0] wd, input logic [2:0] rv,
                               input logic [47:0] ra, input logic [3:0] e1,
                               input logic [3:0] e2, input logic [15:0] ed,
                               input bit push);
    wr_valid = wv;
    wr_addr  = wa;
    wr_data  = wd;
    rd_valid = rv;
    rd_addr  = ra;
    #3;
    checkOutput($sformatf("%s lat1 grant", name), 48'({rd_ready1, wr_ready1}), 48'(e1));
    checkOutput($sformatf("%s lat2 grant", name), 48'({rd_ready2, wr_ready2}), 48'(e2));
    for (int c = 0; c < 3; c++) begin
      if (push && e1[c+1]) q1.push_back('{cyc: cyc + 1, ch: c, data: ed});
      if (push && e2[c+1]) q2.push_back('{cyc: cyc + 2, ch: c, data: ed});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus("idle", 1'b0, 16'h0, 16'h0, 3'b000, 48'h0, GN, GN, 16'h0, 1'b0);
  endtask

  // Scoreboard side: compare any response strobe against the queue head and
  // flag expected responses whose cycle has passed without a strobe.
  task automatic monitorDut(input int which, input logic [2:0] v, input logic [47:0] d);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (which == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
    if (which == 2 && q2.size() > 0) begin e = q2[0]; have = 1'b1; end
    if (have && e.cyc < cyc) begin
      total++;
      $display("[TB] FAIL lat%0d missing rsp: ch%0d none by cycle %0d, expected at %0d data 0x%0h",
               which, e.ch, cyc, e.cyc, e.data);
      if (which == 1) void'(q1.pop_front()); else void'(q2.pop_front());
      have = 1'b0;
    end
    if (v != 3'b000) begin
      if (!have) begin
        total++;
        $display("[TB] FAIL lat%0d unexpected rsp: rsp_valid 0x%0h at cycle %0d, expected none",
                 which, v, cyc);
      end else begin
        if (which == 1) void'(q1.pop_front()); else void'(q2.pop_front());
        checkOutput($sformatf("lat%0d rsp_valid", which), 48'(v), 48'(3'b001 << e.ch));
        checkOutput($sformatf("lat%0d rsp cycle", which), 48'(cyc), 48'(e.cyc));
        checkOutput($sformatf("lat%0d rsp_data ch%0d", which, e.ch), 48'(d[16*e.ch +: 16]),
                    48'(e.data));
      end
    end
  endtask

  always @(negedge clk) begin
    monitorDut(1, rsp_valid1, rsp_data1);
    monitorDut(2, rsp_valid2, rsp_data2);
  end

  task automatic resetDut(input int cycles);
    wr_valid = 1'b0;
    rd_valid = 3'b000;
    rst_n    = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [3:0] order [8];

  initial begin
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_valid = '0;
    rd_addr  = '0;
    order    = '{GW, G0, G1, G2, GW, G0, G1, G2};

    // Reset held with every requester asking: nothing may be granted.
    @(posedge clk);
    #1;
    wr_valid = 1'b1;
    rd_valid = 3'b111;
    #3;
    checkOutput("reset wr_ready", 48'(wr_ready1), 48'h0);
    checkOutput("reset rd_ready", 48'(rd_ready1), 48'h0);
    checkOutput("reset rsp_valid", 48'(rsp_valid1), 48'h0);
    checkOutput("reset rsp_data", rsp_data1, 48'h0);
    checkOutput("reset lat2 ready", 48'({rd_ready2, wr_ready2}), 48'h0);
    checkOutput("reset lat2 rsp_data", rsp_data2, 48'h0);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_valid = 3'b000;
    rst_n    = 1'b1;

    // Write then read back on opA the following cycle.
    applyStimulus("wr 0x12", 1'b1, 16'h0012, 16'hBEEF, 3'b000, 48'h0, GW, GW, 16'h0, 1'b0);
    applyStimulus("rd1 0x12", 1'b0, 16'h0, 16'h0, 3'b010, ra1(1, 16'h0012), G1, G1, 16'hBEEF, 1'b1);

    // Address wrap: 0x0105 and 0x0005 are the same word when DEPTH=256.
    applyStimulus("wr 0x105", 1'b1, 16'h0105, 16'h1234, 3'b000, 48'h0, GW, GW, 16'h0, 1'b0);
    applyStimulus("wr 7 old", 1'b1, 16'h0007, 16'h0055, 3'b000, 48'h0, GW, GW, 16'h0, 1'b0);
    applyStimulus("rd2 wrap", 1'b0, 16'h0, 16'h0, 3'b100, ra1(2, 16'h0005), G2, G2, 16'h1234, 1'b1);

    // Pointer back at W: same-address write and read collide, write wins,
    // read follows next cycle and sees the new word.
    applyStimulus("same W", 1'b1, 16'h0007, 16'h00AA, 3'b001, ra1(0, 16'h0007), GW, GW, 16'h0, 1'b1);
    applyStimulus("same R0", 1'b0, 16'h0, 16'h0, 3'b001, ra1(0, 16'h0007), G0, G0, 16'h00AA, 1'b1);
    idle(3);

    // Everyone asks continuously from reset; in-flight reads sit out.
    resetDut(2);
    for (int k = 0; k < 8; k++)
      applyStimulus($sformatf("stress %0d", k), 1'b1, 16'h0030, 16'h1357, 3'b111,
                    {3{16'h0012}}, order[k], order[k], 16'hBEEF, 1'b1);
`ifdef ACC_MEM_STATS_EN
    checkOutput("lat1 stat_grants", 48'(stat_grants1), 48'd8);
    checkOutput("lat1 stat_conflicts", 48'(stat_conflicts1), 48'd8);
    checkOutput("lat2 stat_grants", 48'(stat_grants2), 48'd8);
    checkOutput("lat2 stat_conflicts", 48'(stat_conflicts2), 48'd8);
`endif
    idle(3);

    // Reset the cycle after a read grant: that read must never respond.
    applyStimulus("pre-reset rd1", 1'b0, 16'h0, 16'h0, 3'b010, ra1(1, 16'h0012), G1, G1, 16'h0, 1'b0);
    rst_n    = 1'b0;
    rd_valid = 3'b000;
    #3;
    checkOutput("in-reset lat2 rsp_valid", 48'(rsp_valid2), 48'h0);
    @(posedge clk);
    #4;
    checkOutput("in-reset lat2 rsp_valid late", 48'(rsp_valid2), 48'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    applyStimulus("post-reset W", 1'b1, 16'h0040, 16'h4444, 3'b010, ra1(1, 16'h0012), GW, GW, 16'h0, 1'b1);
    applyStimulus("post-reset R1", 1'b0, 16'h0, 16'h0, 3'b010, ra1(1, 16'h0012), G1, G1, 16'hBEEF, 1'b1);

    // Held fetch request: LAT1 re-grants every 2 cycles, LAT2 every 3.
    applyStimulus("hold g", 1'b0, 16'h0, 16'h0, 3'b001, ra1(0, 16'h0030), G0, G0, 16'h1357, 1'b1);
    applyStimulus("hold g+1", 1'b0, 16'h0, 16'h0, 3'b001, ra1(0, 16'h0030), GN, GN, 16'h1357, 1'b1);
    applyStimulus("hold g+2", 1'b0, 16'h0, 16'h0, 3'b001, ra1(0, 16'h0030), G0, GN, 16'h1357, 1'b1);
    applyStimulus("hold g+3", 1'b0, 16'h0, 16'h0, 3'b001, ra1(0, 16'h0030), GN, G0, 16'h1357, 1'b1);
    idle(4);

    checkOutput("lat1 queue drained", 48'(q1.size()), 48'h0);
    checkOutput("lat2 queue drained", 48'(q2.size()), 48'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/acc_mem_responder.md
Name: acc_mem_responder

Overview:
- Memory-side responder for the accumulator core's memory interface. Serves instruction fetch, two operand-read channels (LOAD/ADD/string source) and one write channel (STORE/string destination).
- Holds a DEPTH x 16 word array behind a single access port. Arbitrates requests round-robin with valid/ready handshakes and returns read data after a fixed latency.
- Replaces the zero-latency combinational memory the core assumes today, so the core can be driven against realistic timing.

Parameters:
- DEPTH, 256, number of 16-bit words; power of two, 2..65536.
- READ_LAT, 1, cycles from read grant to rsp_valid; legal values 1 or 2.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write granted this cycle.
- wr_addr  in  16  write word address.
- wr_data  in  16  write data.
- rd_valid  in  3  read requests; bit0 fetch, bit1 opA, bit2 opB.
- rd_ready  out  3  per-channel read grant this cycle.
- rd_addr  in  48  packed addresses; channel i at [16i+15:16i].
- rsp_valid  out  3  per-channel one-cycle response strobe.
- rsp_data  out  48  packed response data, same packing as rd_addr.

Behaviour:
- Address handling: only addr[log2(DEPTH)-1:0] is used; higher bits ignored, so addresses wrap modulo DEPTH.
- Requesters are arbitrated in ring order W, R0, R1, R2.
  - A read channel is eligible only while it has no request in flight.
  - Exactly one grant per cycle, or none if nothing is eligible.
  - The grant pointer starts at W and moves to one past the last granted requester; it holds when idle.
- ready outputs are combinational from valid, eligibility and the pointer. Transfer occurs when valid && ready. Requesters must hold valid and addr/data stable until ready.
- Write: the array updates at the granting clock edge. A read granted on any later cycle returns the new data.
- Read with READ_LAT=1:
  - The array is read on the grant edge into a response register.
  - rsp_valid[i] is high for exactly the following cycle, with rsp_data[i] valid during it.
  - The in-flight bit clears as rsp_valid drives, so a channel can complete at most one read every 2 cycles.
- Read with READ_LAT=2: one more pipeline stage; rsp_valid is 2 cycles after the grant.
- Responses have no backpressure. rsp_data[i] holds its last value while rsp_valid[i]=0.
- Simultaneous write and read to the same address in one cycle: only one is granted. The read sees old or new data according to ring order, and this is deterministic.
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - wr_ready=0, rd_ready=0, rsp_valid=0, rsp_data=0.
  - Grant pointer returns to W; all in-flight bits clear.
  - Array contents are not reset.
- Reset mid-operation drops in-flight reads; no response is ever produced for them.
- Out-of-range READ_LAT is a compile-time error.

Optional Feature:
- Macro ACC_MEM_STATS_EN.
- When defined, adds outputs stat_grants (out, 16) and stat_conflicts (out, 16), both reset to 0:
  - stat_grants increments on every grant.
  - stat_conflicts increments on every cycle where two or more requesters present valid.
  - Both saturate at 16'hFFFF.
- When undefined, these ports and the counter logic are absent and behaviour is otherwise identical.

Decomposition:
- Package acc_mem_pkg holds:
  - requester index constants: REQ_W=0, REQ_R0=1, REQ_R1=2, REQ_R2=3, NUM_REQ=4;
  - the rd channel count;
  - a helper function for address-bit width.
- One sub-module: acc_mem_rr_arb, a 4-way round-robin arbiter taking an eligible mask and returning a one-hot grant plus pointer update.
- The array and response pipeline stay in the top module.

Test Plan:
- After reset: write addr 0x0012 data 0xBEEF; one cycle later read channel 1 at addr 0x0012 -> rsp_valid[1] one cycle after grant (READ_LAT=1), rsp_data[1]=0xBEEF.
- Wrap: DEPTH=256, write addr 0x0105 data 0x1234, then read addr 0x0005 -> 0x1234.
- All four requesters valid continuously for 8 cycles from reset -> grant order W,R0,R1,R2,W,R0,... with read channels skipped while in flight. No channel waits more than 4 cycles. With ACC_MEM_STATS_EN, stat_conflicts=8.
- READ_LAT=2: read granted at cycle 10 -> rsp_valid at cycle 12 only; rd_ready for that channel is 0 during cycles 11-12.
- Same cycle: pointer at W, write addr 7 data 0x00AA and read R0 addr 7 (old data 0x0055) -> W granted first, R0 granted next cycle and returns 0x00AA.
- rst_n asserted the cycle after a read grant -> rsp_valid stays 0 through and after reset; the next grant after reset goes to W if it is valid.
